sram_mem_controller: RTL and testbench
======================================

Name: sram_mem_controller

Overview:
- Multi-cycle controller between the MEM pipeline stage and an external 16-bit asynchronous SRAM.
- Accepts the 32-bit read/write requests produced for MEM-mode instructions and splits each into two 16-bit half accesses with programmable wait states.
- Drives `ready`; the hazard/freeze logic stalls every pipeline register while `ready` is low.

Parameters:
- BASE_ADDR, 1024: data-memory base. SRAM word offset = (address - BASE_ADDR) >> 2, truncated to 17 bits.
- WAIT_STATES, 1: extra cycles each half access is held (0..7).
- SRAM_AW, 18: SRAM address width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rd_en  in  1  MEM-stage memory read request
- wr_en  in  1  MEM-stage memory write request
- address  in  32  byte address from EXE result
- write_data  in  32  store data
- read_data  out  32  load data; valid while ready=1 in DONE
- ready  out  1  0 = transaction in progress, pipeline must freeze
- sram_addr  out  SRAM_AW  half-word address
- sram_dq_in  in  16  SRAM data bus, read direction
- sram_dq_out  out  16  SRAM data bus, write direction
- sram_dq_oe  out  1  1 = drive sram_dq_out onto the pad
- sram_we_n, sram_oe_n, sram_ce_n  out  1 each  active-low strobes
- misaligned  out  1  present only with SRAM_ALIGN_CHECK_EN

Behaviour:
- Reset (async, immediate, including mid-transaction):
  - state=IDLE, wait counter=0, read_data=0, sram_addr=0, sram_dq_out=0.
  - sram_dq_oe=0, sram_we_n=1, sram_oe_n=1, sram_ce_n=1, misaligned=0.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: ready = ~(rd_en|wr_en). On a request, latch op, offset and write_data, then go to LO; counter=0.
  - LO: sram_addr={offset,1'b0}; held WAIT_STATES+1 cycles (counter 0..WAIT_STATES), then go to HI with counter cleared.
  - HI: sram_addr={offset,1'b1}; same timing, then go to DONE.
  - DONE: ready=1 for exactly one cycle; next state is IDLE unconditionally. A request still asserted in the following IDLE cycle is treated as a new transaction (the pipeline has advanced by then).
- ready is low in LO and HI.
- Latency: 2*WAIT_STATES+3 ready-low cycles per access (5 at the default). The request-acceptance cycle in IDLE is the first of these.
- Read strobes: sram_ce_n=0, sram_oe_n=0, sram_dq_oe=0 throughout LO/HI.
  - On the last cycle of LO, capture sram_dq_in into read_data[15:0].
  - On the last cycle of HI, capture sram_dq_in into read_data[31:16].
  - read_data otherwise holds its value.
- Write strobes: sram_ce_n=0, sram_dq_oe=1 throughout LO/HI.
  - sram_dq_out = latched data[15:0] in LO, [31:16] in HI.
  - sram_we_n=0 only on the last cycle of each half, so the address is set up for WAIT_STATES cycles; with WAIT_STATES=0 it is low for the single cycle.
- rd_en and wr_en both high in IDLE: write wins.
- Inputs are ignored outside IDLE. Deasserting a request mid-transaction does not abort it; the transaction completes.
- Address below BASE_ADDR: the subtraction wraps and the access proceeds. No trap.
- Address bits [1:0] are ignored for the access.

Optional Feature:
- Macro: SRAM_ALIGN_CHECK_EN.
- Defined: misaligned is set when a request is accepted with address[1:0]!=0. It is sticky until reset. The access still proceeds word-aligned.
- Undefined: the misaligned port and its logic are absent; alignment is silently ignored.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - state encoding (IDLE=2'd0, LO=2'd1, HI=2'd2, DONE=2'd3);
  - default BASE_ADDR and WAIT_STATES;
  - the half-select encoding.
- One natural sub-module, sram_wait_counter: a 3-bit counter with clear and a terminal flag (count==WAIT_STATES). It is instantiated once and cleared on every state change.

Test Plan:
- Write, WAIT_STATES=1: wr_en=1, address=1028, write_data=32'hDEADBEEF.
  - ready low for exactly 5 cycles.
  - sram_addr=2 with dq_out=16'hBEEF, then sram_addr=3 with dq_out=16'hDEAD.
  - One we_n low pulse per half.
  - ready=1 in cycle 5.
- Read-back: rd_en=1, address=1028, SRAM model returning the stored halves.
  - read_data=32'hDEADBEEF while ready=1; oe_n=0; dq_oe=0 throughout.
- Back-to-back: load then store held on consecutive instructions.
  - Two separate 5-cycle ready-low windows, separated by a single ready=1 DONE cycle.
- Conflict and abort:
  - rd_en=wr_en=1 → write performed.
  - rd_en dropped during LO → the read still completes with the full latency.
- Reset mid-HI: rst pulsed in HI.
  - Same cycle: we_n=1, ce_n=1, dq_oe=0.
  - After release: state IDLE, ready=1 with no request.
- WAIT_STATES=0 build: 3 ready-low cycles per access. With SRAM_ALIGN_CHECK_EN, address=1030 sets misaligned=1, and it stays set across later aligned accesses until reset.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
// Holds the controller state encoding, the half-word select encoding used as the
// SRAM address LSB, and the default configuration values.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLo   = 2'd1,
        StHi   = 2'd2,
        StDone = 2'd3
    } ctrl_state_e;

    // Half-word select; becomes the LSB of the SRAM half-word address.
    typedef enum logic {
        HalfLo = 1'b0,
        HalfHi = 1'b1
    } half_sel_e;

    localparam int unsigned DefBaseAddr   = 1024;
    localparam int unsigned DefWaitStates = 1;
    localparam int unsigned DefSramAw     = 18;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter for one SRAM half access.
// Counts 0..WAIT_STATES while enabled and then holds at the terminal value.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clear          synchronous clear (asserted on every controller state change)
//   en             count enable
//   terminal       count == WAIT_STATES (last cycle of the half access)
//   almost         count + 1 == WAIT_STATES (next cycle is the last, if not cleared)
module sram_wait_counter
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_STATES = DefWaitStates
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic terminal,
    output logic almost
);

    localparam logic [2:0] Last = 3'(WAIT_STATES);

    logic [2:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !terminal) begin
            count <= count + 3'd1;
        end
    end

    assign terminal = (count == Last);
    assign almost   = (3'(count + 3'd1) == Last);

endmodule

// File: rtl/sram_mem_controller.sv
// Multi-cycle controller between the MEM pipeline stage and a 16-bit asynchronous SRAM.
// Each 32-bit request is split into a low and a high half access, each held for
// WAIT_STATES+1 cycles. ready is low while a transaction is in flight.
// Optional feature: define SRAM_ALIGN_CHECK_EN to add the sticky 'misaligned' output.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   rd_en, wr_en                     MEM-stage read / write request (write wins)
//   address, write_data              byte address and store data
//   read_data                        load data, valid while ready=1 in DONE
//   ready                            0 = transaction in progress, freeze pipeline
//   sram_addr                        half-word address {word offset, half}
//   sram_dq_in/sram_dq_out/sram_dq_oe  SRAM data bus, split by direction
//   sram_we_n, sram_oe_n, sram_ce_n  active-low SRAM strobes
//   misaligned                       (SRAM_ALIGN_CHECK_EN only) sticky alignment flag
module sram_mem_controller
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DefBaseAddr,
    parameter int unsigned WAIT_STATES = DefWaitStates,
    parameter int unsigned SRAM_AW     = DefSramAw
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [15:0]        sram_dq_in,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n
`ifdef SRAM_ALIGN_CHECK_EN
    ,
    output logic               misaligned
`endif
);

    localparam int unsigned OffW   = SRAM_AW - 1;
    localparam logic        NoWait = (WAIT_STATES == 0);

    ctrl_state_e     state_q, state_d;
    logic            op_write_q;
    logic [OffW-1:0] offset_q;
    logic [31:0]     wdata_q;
    logic [OffW-1:0] word_off;
    logic            req;
    logic            cnt_clear, cnt_en, cnt_term, cnt_almost;

    assign req = rd_en | wr_en;
    // Below-base addresses wrap; the truncated offset is used as-is.
    assign word_off = OffW'((address - 32'(BASE_ADDR)) >> 2);

    assign cnt_clear = (state_d != state_q);
    assign cnt_en    = (state_q == StLo) || (state_q == StHi);

    sram_wait_counter #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .en       (cnt_en),
        .terminal (cnt_term),
        .almost   (cnt_almost)
    );

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready = ~req;
                if (req) state_d = StLo;
            end
            StLo:    if (cnt_term) state_d = StHi;
            StHi:    if (cnt_term) state_d = StDone;
            StDone: begin
                ready   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes are registered for the state being entered, so they are
    // glitch-free and valid for the whole of each half access. we_n is
    // scheduled one cycle ahead so it lands on the last cycle of each half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_write_q  <= 1'b0;
            offset_q    <= '0;
            wdata_q     <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_ce_n   <= 1'b1;
`ifdef SRAM_ALIGN_CHECK_EN
            misaligned  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        op_write_q <= wr_en;
                        offset_q   <= word_off;
                        wdata_q    <= write_data;
                        sram_addr  <= {word_off, HalfLo};
                        sram_ce_n  <= 1'b0;
                        sram_oe_n  <= wr_en;
                        sram_dq_oe <= wr_en;
                        sram_we_n  <= ~(wr_en & NoWait);
                        if (wr_en) sram_dq_out <= write_data[15:0];
`ifdef SRAM_ALIGN_CHECK_EN
                        if (address[1:0] != 2'b00) misaligned <= 1'b1;
`endif
                    end
                end
                StLo: begin
                    if (cnt_term) begin
                        if (!op_write_q) read_data[15:0] <= sram_dq_in;
                        if (op_write_q) sram_dq_out <= wdata_q[31:16];
                        sram_addr <= {offset_q, HalfHi};
                        sram_we_n <= ~(op_write_q & NoWait);
                    end else begin
                        sram_we_n <= ~(op_write_q & cnt_almost);
                    end
                end
                StHi: begin
                    if (cnt_term) begin
                        if (!op_write_q) read_data[31:16] <= sram_dq_in;
                        sram_ce_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                    end else begin
                        sram_we_n <= ~(op_write_q & cnt_almost);
                    end
                end
                StDone: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench for sram_mem_controller: one instance at WAIT_STATES=1
// driven from a vector table plus corner-case sequences, and one at WAIT_STATES=0.
module tb_sram_mem_controller;

    logic clk;
    logic rst;

    // WAIT_STATES=1 instance
    logic        rd_en, wr_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] dq_in, dq_out;
    logic        dq_oe, we_n, oe_n, ce_n;
`ifdef SRAM_ALIGN_CHECK_EN
    logic        mis;
`endif

    // WAIT_STATES=0 instance
    logic        z_rd, z_wr;
    logic [31:0] z_addr, z_wd, z_read_data;
    logic        z_ready;
    logic [17:0] z_sram_addr;
    logic [15:0] z_dq_in, z_dq_out;
    logic        z_dq_oe, z_we_n, z_oe_n, z_ce_n;
`ifdef SRAM_ALIGN_CHECK_EN
    logic        z_mis;
`endif

    int errors = 0;
    int checks = 0;

    sram_mem_controller #(
        .BASE_ADDR   (1024),
        .WAIT_STATES (1),
        .SRAM_AW     (18)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_in  (dq_in),
        .sram_dq_out (dq_out),
        .sram_dq_oe  (dq_oe),
        .sram_we_n   (we_n),
        .sram_oe_n   (oe_n),
        .sram_ce_n   (ce_n)
`ifdef SRAM_ALIGN_CHECK_EN
        ,
        .misaligned  (mis)
`endif
    );

    sram_mem_controller #(
        .BASE_ADDR   (1024),
        .WAIT_STATES (0),
        .SRAM_AW     (18)
    ) dut_z (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (z_rd),
        .wr_en       (z_wr),
        .address     (z_addr),
        .write_data  (z_wd),
        .read_data   (z_read_data),
        .ready       (z_ready),
        .sram_addr   (z_sram_addr),
        .sram_dq_in  (z_dq_in),
        .sram_dq_out (z_dq_out),
        .sram_dq_oe  (z_dq_oe),
        .sram_we_n   (z_we_n),
        .sram_oe_n   (z_oe_n),
        .sram_ce_n   (z_ce_n)
`ifdef SRAM_ALIGN_CHECK_EN
        ,
        .misaligned  (z_mis)
`endif
    );

    // Small SRAM models indexed by the low address bits.
    logic [15:0] mem1 [16];
    logic [15:0] mem0 [16];

    always @(posedge clk) begin
        if (!ce_n && !we_n) mem1[sram_addr[3:0]] <= dq_out;
        if (!z_ce_n && !z_we_n) mem0[z_sram_addr[3:0]] <= z_dq_out;
    end

    assign dq_in   = (!ce_n && !oe_n) ? mem1[sram_addr[3:0]] : 16'h0000;
    assign z_dq_in = (!z_ce_n && !z_oe_n) ? mem0[z_sram_addr[3:0]] : 16'h0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Runs one transaction on the WAIT_STATES=1 instance starting at a negedge.
    // Returns at the negedge of the DONE cycle with the request still applied.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, output int lat, output int gap,
                           output int we_cnt, output logic [17:0] wa0, output logic [15:0] wd0,
                           output logic [17:0] wa1, output logic [15:0] wd1, output int bad);
        logic done;
        lat = 0; gap = 0; we_cnt = 0; bad = 0;
        wa0 = '0; wd0 = '0; wa1 = '0; wd1 = '0;
        done = 1'b0;
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        #1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (i > 0) @(negedge clk);
            if (ready) begin
                if (lat > 0) done = 1'b1;
                else gap++;
            end else begin
                lat++;
                if (lat > 1) begin
                    if (ce_n !== 1'b0 || dq_oe !== wr || oe_n !== wr) bad++;
                    if (we_n === 1'b0) begin
                        if (we_cnt == 0) begin wa0 = sram_addr; wd0 = dq_out; end
                        else begin wa1 = sram_addr; wd1 = dq_out; end
                        we_cnt++;
                    end
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout: got lat=%0d, expected completion within 40 cycles", lat);
        end
    endtask

    // Drops the request and steps into the following IDLE cycle.
    task automatic go_idle();
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_z(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output int lat);
        logic done;
        lat = 0;
        done = 1'b0;
        z_rd = rd; z_wr = wr; z_addr = a; z_wd = d;
        #1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (i > 0) @(negedge clk);
            if (!z_ready) lat++;
            else if (lat > 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL z_timeout: got lat=%0d, expected completion within 20 cycles", lat);
        end
        z_rd = 1'b0; z_wr = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic [17:0] ea0;
        logic [15:0] ed0;
        logic [17:0] ea1;
        logic [15:0] ed1;
    } vec_t;

    vec_t vt[7];

    initial begin
        int lat, gap, we_cnt, bad;
        logic [17:0] wa0, wa1;
        logic [15:0] wd0, wd1;

        vt[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h0, 18'd2, 16'hBEEF, 18'd3, 16'hDEAD};
        vt[1] = '{1'b1, 1'b0, 32'd1028, 32'h0, 32'hDEADBEEF, 18'd0, 16'h0, 18'd0, 16'h0};
        vt[2] = '{1'b1, 1'b1, 32'd1032, 32'h12345678, 32'h0, 18'd4, 16'h5678, 18'd5, 16'h1234};
        vt[3] = '{1'b1, 1'b0, 32'd1032, 32'h0, 32'h12345678, 18'd0, 16'h0, 18'd0, 16'h0};
        vt[4] = '{1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 32'h0, 18'h3FFFE, 16'hF00D,
                  18'h3FFFF, 16'hCAFE};
        vt[5] = '{1'b1, 1'b0, 32'd1031, 32'h0, 32'hDEADBEEF, 18'd0, 16'h0, 18'd0, 16'h0};
        vt[6] = '{1'b1, 1'b0, 32'd1020, 32'h0, 32'hCAFEF00D, 18'd0, 16'h0, 18'd0, 16'h0};

        rst = 1'b1;
        rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        z_rd = 1'b0; z_wr = 1'b0; z_addr = '0; z_wd = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_we_n", {31'd0, we_n}, 32'd1);
        check("rst_oe_n", {31'd0, oe_n}, 32'd1);
        check("rst_ce_n", {31'd0, ce_n}, 32'd1);
        check("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
        check("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_dq_out", {16'd0, dq_out}, 32'd0);
        check("rst_z_ready", {31'd0, z_ready}, 32'd1);
`ifdef SRAM_ALIGN_CHECK_EN
        check("rst_misaligned", {31'd0, mis}, 32'd0);
`endif

        // Vector table on the WAIT_STATES=1 instance
        foreach (vt[k]) begin
            run_txn(vt[k].rd, vt[k].wr, vt[k].a, vt[k].d, lat, gap, we_cnt, wa0, wd0, wa1, wd1,
                    bad);
            check($sformatf("v%0d_latency", k), lat, 32'd5);
            check($sformatf("v%0d_gap", k), gap, 32'd0);
            check($sformatf("v%0d_strobes", k), bad, 32'd0);
            if (vt[k].wr) begin
                check($sformatf("v%0d_we_pulses", k), we_cnt, 32'd2);
                check($sformatf("v%0d_addr_lo", k), {14'd0, wa0}, {14'd0, vt[k].ea0});
                check($sformatf("v%0d_data_lo", k), {16'd0, wd0}, {16'd0, vt[k].ed0});
                check($sformatf("v%0d_addr_hi", k), {14'd0, wa1}, {14'd0, vt[k].ea1});
                check($sformatf("v%0d_data_hi", k), {16'd0, wd1}, {16'd0, vt[k].ed1});
            end else begin
                check($sformatf("v%0d_we_pulses", k), we_cnt, 32'd0);
                check($sformatf("v%0d_read_data", k), read_data, vt[k].exp_rd);
            end
            go_idle();
            #1;
            check($sformatf("v%0d_idle_ready", k), {31'd0, ready}, 32'd1);
        end
`ifdef SRAM_ALIGN_CHECK_EN
        check("misaligned_after_1031", {31'd0, mis}, 32'd1);
`endif

        // Read with rd_en dropped during LO still completes
        rd_en = 1'b1; address = 32'd1032;
        lat = 0;
        #1;
        if (!ready) lat++;
        @(negedge clk);
        rd_en = 1'b0;
        begin
            logic done;
            done = 1'b0;
            for (int i = 0; i < 20 && !done; i++) begin
                if (i > 0) @(negedge clk);
                #1;
                if (!ready) lat++;
                else done = 1'b1;
            end
        end
        check("abort_latency", lat, 32'd5);
        check("abort_read_data", read_data, 32'h12345678);
        @(negedge clk);

        // Back-to-back: load then store held on consecutive instructions
        run_txn(1'b1, 1'b0, 32'd1028, 32'h0, lat, gap, we_cnt, wa0, wd0, wa1, wd1, bad);
        check("b2b_load_latency", lat, 32'd5);
        check("b2b_load_data", read_data, 32'hDEADBEEF);
        run_txn(1'b0, 1'b1, 32'd1040, 32'hA5A55A5A, lat, gap, we_cnt, wa0, wd0, wa1, wd1, bad);
        check("b2b_done_gap", gap, 32'd1);
        check("b2b_store_latency", lat, 32'd5);
        check("b2b_store_we", we_cnt, 32'd2);
        check("b2b_store_addr_hi", {14'd0, wa1}, 32'd9);
        check("b2b_store_data_hi", {16'd0, wd1}, 32'h0000A5A5);
        go_idle();

        // WAIT_STATES=0 instance
        run_z(1'b0, 1'b1, 32'd1028, 32'h11112222, lat);
        check("z_write_latency", lat, 32'd3);
        run_z(1'b1, 1'b0, 32'd1028, 32'h0, lat);
        check("z_read_latency", lat, 32'd3);
        check("z_read_data", z_read_data, 32'h11112222);
`ifdef SRAM_ALIGN_CHECK_EN
        check("z_mis_aligned", {31'd0, z_mis}, 32'd0);
        run_z(1'b0, 1'b1, 32'd1030, 32'h33334444, lat);
        check("z_mis_set", {31'd0, z_mis}, 32'd1);
        run_z(1'b1, 1'b0, 32'd1028, 32'h0, lat);
        check("z_mis_sticky", {31'd0, z_mis}, 32'd1);
        check("z_mis_word_aligned", z_read_data, 32'h33334444);
`endif

        // Reset pulsed on the last HI cycle of a write
        wr_en = 1'b1; address = 32'd1044; write_data = 32'h0BAD0BAD;
        repeat (4) @(negedge clk);
        check("midhi_ce_n", {31'd0, ce_n}, 32'd0);
        check("midhi_we_n", {31'd0, we_n}, 32'd0);
        check("midhi_addr", {14'd0, sram_addr}, 32'd11);
        rst = 1'b1;
        #1;
        check("rst_hi_we_n", {31'd0, we_n}, 32'd1);
        check("rst_hi_ce_n", {31'd0, ce_n}, 32'd1);
        check("rst_hi_dq_oe", {31'd0, dq_oe}, 32'd0);
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, ready}, 32'd1);
        check("post_rst_addr", {14'd0, sram_addr}, 32'd0);
        check("post_rst_read_data", read_data, 32'd0);
`ifdef SRAM_ALIGN_CHECK_EN
        check("post_rst_z_mis", {31'd0, z_mis}, 32'd0);
`endif
        @(negedge clk);
        run_txn(1'b1, 1'b0, 32'd1028, 32'h0, lat, gap, we_cnt, wa0, wd0, wa1, wd1, bad);
        check("post_rst_latency", lat, 32'd5);
        check("post_rst_read", read_data, 32'hDEADBEEF);
        go_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
